// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
//   Owns the PC, fetches words over a req/ack handshake, and presents the
//   fetched instruction to decode. Applies jump, jump-register and taken-beq
//   redirects resolved in ID. There is no delay slot, and a taken redirect
//   leaves one bubble in IF/ID.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_req/addr         fetch request and word address (addr stable until ack)
//   imem_ack/rdata        fetch completion and returned instruction word
//   stall                 ID must hold its instruction
//   PCSrc, Branch,
//   branch_zero, rs_data  redirect controls and operands for the ID instruction
//   id_valid/instr/pc_plus4, OpCode, Funct   IF/ID contents
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle after reset, no request, late acks ignored
// FETCH | request at pc outstanding
// DROP  | redirected while a request was in flight; wait for and discard it
// HOLD  | word arrived during a stall; parked in hold regs until ID frees up
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        branch_zero,
    input  logic [31:0] rs_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_plus4_q, hold_pc_plus4_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic        take_branch;
    logic        redirect;

    assign pc_plus4    = pc_q + 32'd4;
    assign branch_off  = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    // PCSrc==11 is not a real encoding; it falls back to the sequential/branch case.
    assign take_branch = ((PCSrc == 2'b00) || (PCSrc == 2'b11)) && Branch && branch_zero;
    assign redirect    = id_valid_q && !stall &&
                         ((PCSrc == 2'b01) || (PCSrc == 2'b10) || take_branch);

    always_comb begin
        case (PCSrc)
            2'b01:   target = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
            2'b10:   target = rs_data;
            default: target = id_pc_plus4_q + branch_off;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_PC;
            pend_pc_q       <= 32'd0;
            id_valid_q      <= 1'b0;
            id_instr_q      <= 32'd0;
            id_pc_plus4_q   <= 32'd0;
            hold_instr_q    <= 32'd0;
            hold_pc_plus4_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pend_pc_q       <= pend_pc_d;
            id_valid_q      <= id_valid_d;
            id_instr_q      <= id_instr_d;
            id_pc_plus4_q   <= id_pc_plus4_d;
            hold_instr_q    <= hold_instr_d;
            hold_pc_plus4_q <= hold_pc_plus4_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_pc_d       = pend_pc_q;
        id_valid_d      = id_valid_q;
        id_instr_d      = id_instr_q;
        id_pc_plus4_d   = id_pc_plus4_q;
        hold_instr_d    = hold_instr_q;
        hold_pc_plus4_d = hold_pc_plus4_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // the word just returned is on the wrong path
                        pc_d          = target;
                        id_valid_d    = 1'b0;
                        id_instr_d    = 32'd0;
                        id_pc_plus4_d = 32'd0;
                    end else if (stall) begin
                        hold_instr_d    = imem_rdata;
                        hold_pc_plus4_d = pc_plus4;
                        pc_d            = pc_plus4;
                        state_d         = S_HOLD;
                    end else begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = imem_rdata;
                        id_pc_plus4_d = pc_plus4;
                        pc_d          = pc_plus4;
                    end
                end else if (redirect) begin
                    // keep imem_addr stable until the in-flight request completes
                    pend_pc_d     = target;
                    id_valid_d    = 1'b0;
                    id_instr_d    = 32'd0;
                    id_pc_plus4_d = 32'd0;
                    state_d       = S_DROP;
                end else if (!stall) begin
                    id_valid_d    = 1'b0;
                    id_instr_d    = 32'd0;
                    id_pc_plus4_d = 32'd0;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    pc_d    = pend_pc_q;
                    state_d = S_FETCH;
                end
                if (!stall) begin
                    id_valid_d    = 1'b0;
                    id_instr_d    = 32'd0;
                    id_pc_plus4_d = 32'd0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        pc_d          = target;
                        id_valid_d    = 1'b0;
                        id_instr_d    = 32'd0;
                        id_pc_plus4_d = 32'd0;
                    end else begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = hold_instr_q;
                        id_pc_plus4_d = hold_pc_plus4_q;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
        imem_addr = pc_q;
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign OpCode      = id_instr_q[31:26];
    assign Funct       = id_instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic        branch = 1'b0;
    logic        branch_zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  op_code;
    logic [5:0]  funct;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .PCSrc(pc_src), .Branch(branch),
        .branch_zero(branch_zero), .rs_data(rs_data),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .OpCode(op_code), .Funct(funct)
    );

    always #5 clk = ~clk;

    // Reference model: fetch pointer, one pending discard, and a queue of
    // words that arrived while decode was stalled.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_discard;
    logic [31:0] m_pend;
    logic [63:0] m_buf[$];
    bit          m_idv;
    logic [31:0] m_idi;
    logic [31:0] m_idp4;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return !m_boot && (m_buf.size() == 0);
    endfunction

    task automatic m_reset();
        m_pc = 32'h0; m_boot = 1; m_discard = 0; m_pend = 0;
        m_buf.delete();
        m_idv = 0; m_idi = 0; m_idp4 = 0;
    endtask

    task automatic m_bubble();
        m_idv = 0; m_idi = 0;
    endtask

    task automatic m_load(input logic [31:0] w, input logic [31:0] p4);
        m_idv = 1; m_idi = w; m_idp4 = p4;
    endtask

    task automatic m_step(input bit ack, input logic [31:0] rdata, input bit stl,
                          input logic [1:0] ps, input bit br, input bit bz,
                          input logic [31:0] rs);
        bit          redir;
        logic [31:0] tgt;
        logic [63:0] e;
        int          off;
        if (rst) begin m_reset(); return; end
        redir = m_idv && !stl &&
                (ps == 2'd1 || ps == 2'd2 || ((ps == 2'd0 || ps == 2'd3) && br && bz));
        off = $signed(m_idi[15:0]);
        if (ps == 2'd1)      tgt = (m_idp4 & 32'hF000_0000) | ((m_idi & 32'h03FF_FFFF) << 2);
        else if (ps == 2'd2) tgt = rs;
        else                 tgt = m_idp4 + 32'(off * 4);

        if (m_boot) begin
            m_boot = 0;
        end else if (m_buf.size() != 0) begin
            if (!stl) begin
                if (redir) begin
                    m_pc = tgt; m_bubble(); m_buf.delete();
                end else begin
                    e = m_buf.pop_front();
                    m_load(e[63:32], e[31:0]);
                end
            end
        end else if (m_discard) begin
            if (ack) begin m_pc = m_pend; m_discard = 0; end
            if (!stl) m_bubble();
        end else if (ack) begin
            if (redir) begin
                m_pc = tgt; m_bubble();
            end else if (stl) begin
                m_buf.push_back({rdata, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end else begin
                m_load(rdata, m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end
        end else if (redir) begin
            m_pend = tgt; m_discard = 1; m_bubble();
        end else if (!stl) begin
            m_bubble();
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit ack, input logic [31:0] rdata, input bit stl,
                        input logic [1:0] ps, input bit br, input bit bz,
                        input logic [31:0] rs);
        imem_ack = ack; imem_rdata = rdata; stall = stl;
        pc_src = ps; branch = br; branch_zero = bz; rs_data = rs;
        m_step(ack, rdata, stl, ps, br, bz, rs);
        @(posedge clk);
        #1;
        chk_eq("req", 32'(imem_req), 32'(m_req()));
        if (m_req()) chk_eq("addr", imem_addr, m_pc);
        chk_eq("id_valid", 32'(id_valid), 32'(m_idv));
        chk_eq("id_instr", id_instr, m_idi);
        if (m_idv) chk_eq("id_pc_plus4", id_pc_plus4, m_idp4);
        chk_eq("opcode", 32'(op_code), 32'(m_idi[31:26]));
        chk_eq("funct", 32'(funct), 32'(m_idi[5:0]));
    endtask

    task automatic fetch(input logic [31:0] w);
        step(1, w, 0, 2'd0, 0, 0, 32'd0);
    endtask

    initial begin
        bit ack_r;
        m_reset();
        // reset and sequential fetch
        rst = 1;
        step(0, 0, 0, 2'd0, 0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0, 0);
        chk_eq("rst_req", 32'(imem_req), 32'd0);
        chk_eq("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        rst = 0;
        step(0, 0, 0, 2'd0, 0, 0, 0);
        chk_eq("boot_addr", imem_addr, 32'h0);
        fetch(32'h2008_0001);
        chk_eq("seq_instr0", id_instr, 32'h2008_0001);
        chk_eq("seq_p4_0", id_pc_plus4, 32'h4);
        fetch(32'h2009_0002);
        chk_eq("seq_p4_1", id_pc_plus4, 32'h8);
        chk_eq("seq_addr", imem_addr, 32'h8);
        fetch(32'h0000_0020);
        fetch(32'h1109_FFFF);
        chk_eq("beq_p4", id_pc_plus4, 32'h10);

        // beq not taken, then jr back to the beq and take it
        step(1, 32'h0000_0020, 0, 2'd0, 1, 0, 0);
        chk_eq("beq_nt_addr", imem_addr, 32'h14);
        step(1, 32'hDEAD_BEEF, 0, 2'd2, 0, 0, 32'h0000_000C);
        chk_eq("jr_c_addr", imem_addr, 32'h0C);
        fetch(32'h1109_FFFF);
        step(1, 32'hDEAD_BEEF, 0, 2'd0, 1, 1, 0);
        chk_eq("beq_t_addr", imem_addr, 32'h0C);
        chk_eq("beq_t_bubble", 32'(id_valid), 32'd0);

        // jr and j
        fetch(32'h2008_0001);
        step(1, 32'hDEAD_BEEF, 0, 2'd2, 0, 0, 32'h0000_0080);
        chk_eq("jr_addr", imem_addr, 32'h80);
        fetch(32'h2008_0001);
        step(1, 32'hDEAD_BEEF, 0, 2'd2, 0, 0, 32'h9000_0000);
        fetch(32'h0810_0040);
        chk_eq("j_p4", id_pc_plus4, 32'h9000_0004);
        step(1, 32'hDEAD_BEEF, 0, 2'd1, 0, 0, 0);
        chk_eq("j_addr", imem_addr, 32'h9040_0100);

        // redirect with ack withheld
        fetch(32'h2009_0002);
        step(0, 0, 0, 2'd1, 0, 0, 0);
        chk_eq("drop_addr0", imem_addr, 32'h9040_0104);
        step(0, 0, 0, 2'd1, 0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0, 0);
        chk_eq("drop_addr2", imem_addr, 32'h9040_0104);
        step(1, 32'hBAD0_BAD0, 0, 2'd0, 0, 0, 0);
        chk_eq("drop_tgt", imem_addr, 32'h9024_0008);
        chk_eq("drop_no_stale", 32'(id_valid), 32'd0);

        // stall during ack
        fetch(32'h2008_0001);
        step(1, 32'hAAAA_0001, 1, 2'd0, 0, 0, 0);
        chk_eq("hold_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd0, 0, 0, 0);
        chk_eq("hold_id", id_instr, 32'h2008_0001);
        step(0, 0, 0, 2'd0, 0, 0, 0);
        chk_eq("hold_rel", id_instr, 32'hAAAA_0001);
        chk_eq("hold_rel_p4", id_pc_plus4, 32'h9024_0010);
        fetch(32'h2009_0002);
        chk_eq("hold_next_p4", id_pc_plus4, 32'h9024_0014);

        // reset during a fetch wait, with a late ack afterwards
        step(0, 0, 0, 2'd0, 0, 0, 0);
        rst = 1;
        step(1, 32'h1234_5678, 0, 2'd0, 0, 0, 0);
        chk_eq("mid_rst_req", 32'(imem_req), 32'd0);
        chk_eq("mid_rst_idv", 32'(id_valid), 32'd0);
        rst = 0;
        step(1, 32'h1234_5678, 0, 2'd0, 0, 0, 0);
        chk_eq("mid_rst_addr", imem_addr, 32'h0);
        chk_eq("mid_rst_late_ack", 32'(id_valid), 32'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            ack_r = m_req() && ($urandom_range(0, 2) != 0);
            step(ack_r, $urandom(), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
